// File: rtl/wb_result_tracer.sv
// wb_result_tracer: FIFO trace of register-file writebacks with drop/retire accounting.
// The head entry is pre-registered so out_* never depend combinationally on wb_*.
module wb_result_tracer #(
    parameter int DEPTH       = 16,
    parameter int FILTER_ZERO = 1,
    parameter int CNT_W       = 32
) (
    input  logic                     cclk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wb_en,
    input  logic [4:0]               wb_rd,
    input  logic [31:0]              wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_rd,
    output logic [31:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [CNT_W-1:0]         retire_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, next_rd;
    logic [CW-1:0] next_cnt;
    logic [36:0]   next_head;
    logic          q, pop, push, full, drop, new_head;

    assign out_valid = count != '0;

    always_comb begin
        full      = count == CW'(DEPTH);
        q         = wb_en && !(FILTER_ZERO != 0 && wb_rd == 5'd0);
        pop       = out_valid && out_ready;
        push      = q && (!full || pop);
        drop      = q && full && !pop;
        next_rd   = rd_ptr + AW'(pop);
        next_cnt  = count + CW'(push) - CW'(pop);
        // an entry written into a buffer that is (or is becoming) empty is the new head
        new_head  = push && (count - CW'(pop)) == '0;
        next_head = new_head ? {wb_rd, wb_data} : (next_cnt == '0 ? '0 : mem[next_rd]);
    end

    always_ff @(posedge cclk) begin
        if (push && !clear)
            mem[wr_ptr] <= {wb_rd, wb_data};
    end

    always_ff @(posedge cclk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_rd     <= '0;
            out_data   <= '0;
            overflow   <= 1'b0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_rd     <= '0;
            out_data   <= '0;
            overflow   <= 1'b0;
            retire_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            wr_ptr               <= wr_ptr + AW'(push);
            rd_ptr               <= next_rd;
            count                <= next_cnt;
            {out_rd, out_data}   <= next_head;
            if (drop)
                overflow <= 1'b1;
            if (q && !(&retire_cnt))
                retire_cnt <= retire_cnt + 1'b1;
            if (drop && !(&drop_cnt))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_result_tracer.sv
// tb_wb_result_tracer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_result_tracer;
    logic        cclk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [31:0] retire_cnt, drop_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [36:0] mq[$];
    logic [36:0] seen[$];
    logic        m_ovf;
    logic [31:0] m_ret, m_drop;

    wb_result_tracer #(.DEPTH(16), .FILTER_ZERO(1), .CNT_W(32)) dut (
        .cclk(cclk), .rst(rst), .clear(clear), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .count(count), .overflow(overflow),
        .retire_cnt(retire_cnt), .drop_cnt(drop_cnt)
    );

    always #5 cclk = ~cclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_ret  = '0;
        m_drop = '0;
    endtask

    // What one rising edge must do to the trace, from the stated rules.
    task automatic model_step();
        bit qq, pp, fl;
        if (!rst || clear) begin
            model_reset();
            return;
        end
        qq = wb_en && wb_rd != 0;
        pp = mq.size() != 0 && out_ready;
        fl = mq.size() == 16;
        if (pp) void'(mq.pop_front());
        if (qq) begin
            if (m_ret != 32'hffff_ffff) m_ret++;
            if (!fl || pp) mq.push_back({wb_rd, wb_data});
            else begin
                if (m_drop != 32'hffff_ffff) m_drop++;
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic cyc(input bit en, input logic [4:0] rd, input logic [31:0] d,
                       input bit rdy, input bit clr);
        wb_en = en; wb_rd = rd; wb_data = d; out_ready = rdy; clear = clr;
        @(posedge cclk);
        model_step();
        #1;
    endtask

    always @(negedge cclk) begin
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("count", 64'(count), 64'(mq.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("retire_cnt", 64'(retire_cnt), 64'(m_ret));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (mq.size() != 0) begin
            chk("out_rd", 64'(out_rd), 64'(mq[0][36:32]));
            chk("out_data", 64'(out_data), 64'(mq[0][31:0]));
        end
        if (rst && out_valid && out_ready) seen.push_back({out_rd, out_data});
    end

    initial begin
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) cyc(i[0], 5'd7, 32'h99, 1'b0, 1'b0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd", 64'(out_rd), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_retire", 64'(retire_cnt), 64'd0);
        rst = 1'b1;
        cyc(1'b1, 5'd5, 32'hab, 1'b0, 1'b0);
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_rd", 64'(out_rd), 64'd5);
        chk("first_data", 64'(out_data), 64'hab);

        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        seen.delete();
        cyc(1'b1, 5'd8, 32'h11, 1'b1, 1'b0);
        cyc(1'b1, 5'd9, 32'h22, 1'b1, 1'b0);
        cyc(1'b1, 5'd0, 32'h33, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t2_retire", 64'(retire_cnt), 64'd2);
        chk("t2_seen_n", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            chk("t2_e0", 64'(seen[0]), 64'({5'd8, 32'h11}));
            chk("t2_e1", 64'(seen[1]), 64'({5'd9, 32'h22}));
        end

        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        seen.delete();
        for (int k = 1; k <= 18; k++) cyc(1'b1, 5'(k), 32'(k * 4), 1'b0, 1'b0);
        chk("t3_count", 64'(count), 64'd16);
        chk("t3_drop", 64'(drop_cnt), 64'd2);
        chk("t3_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 20; i++) cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t3_seen_n", 64'(seen.size()), 64'd16);
        for (int i = 0; i < seen.size() && i < 16; i++)
            chk("t3_order", 64'(seen[i][31:0]), 64'((i + 1) * 4));

        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        seen.delete();
        for (int k = 0; k < 16; k++) cyc(1'b1, 5'((k % 31) + 1), 32'(100 + k), 1'b0, 1'b0);
        for (int k = 16; k < 56; k++) cyc(1'b1, 5'((k % 31) + 1), 32'(100 + k), 1'b1, 1'b0);
        chk("t4_count", 64'(count), 64'd16);
        chk("t4_drop", 64'(drop_cnt), 64'd0);
        chk("t4_seen_n", 64'(seen.size()), 64'd40);
        for (int i = 0; i < seen.size() && i < 40; i++)
            chk("t4_order", 64'(seen[i][31:0]), 64'(100 + i));

        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 17; k++) cyc(1'b1, 5'd2, 32'(k), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t5_count", 64'(count), 64'd8);
        chk("t5_ovf", 64'(overflow), 64'd1);
        cyc(1'b1, 5'd3, 32'h55, 1'b1, 1'b1);
        chk("t5_clr_count", 64'(count), 64'd0);
        chk("t5_clr_valid", 64'(out_valid), 64'd0);
        chk("t5_clr_ovf", 64'(overflow), 64'd0);
        chk("t5_clr_retire", 64'(retire_cnt), 64'd0);
        chk("t5_clr_drop", 64'(drop_cnt), 64'd0);

        for (int k = 0; k < 6; k++) cyc(1'b1, 5'(k + 10), 32'(k + 500), 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t6_pre_count", 64'(count), 64'd5);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_count", 64'(count), 64'd0);
        #4 rst = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b1, 5'(k + 20), 32'(k + 700), 1'b0, 1'b0);
        chk("t6_refill", 64'(count), 64'd4);
        seen.delete();
        for (int i = 0; i < 6; i++) cyc(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        chk("t6_seen_n", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) chk("t6_first", 64'(seen[0]), 64'({5'd20, 32'd700}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
